// File: rtl/sa_pkg.sv
// ----------------------------------------------------------------------------
// sa_pkg
// Shared types and helpers for the slave-arbitration blocks. The AW
// arbiter and the WDATA channel block both use these.
//   sa_aw_state_t  : AW scheduler state (IDLE = slave AW slot empty,
//                    ISSUE = slave AWVALID asserted).
//   sa_mst_id_w()  : width of a master index. It is never below 1 bit, so a
//                    single-master build still has a legal vector.
//   sa_wd_order_t  : one WDATA ordering-FIFO entry {mst_id, AxLEN}. It is
//                    sized for the default configuration and used by the
//                    WDATA channel block.
// ----------------------------------------------------------------------------
package sa_pkg;

    typedef enum logic {
        SA_AW_IDLE  = 1'b0,
        SA_AW_ISSUE = 1'b1
    } sa_aw_state_t;

    function automatic int sa_mst_id_w(input int mst_amt);
        return (mst_amt > 1) ? $clog2(mst_amt) : 1;
    endfunction

    localparam int SA_MST_AMT  = 3;
    localparam int SA_MST_ID_W = sa_mst_id_w(SA_MST_AMT);
    localparam int SA_LEN_W    = 3;

    typedef struct packed {
        logic [SA_MST_ID_W-1:0] mst_id;
        logic [SA_LEN_W-1:0]    axlen;
    } sa_wd_order_t;

endpackage

// File: rtl/sa_aw_arbiter_if.sv
// ----------------------------------------------------------------------------
// sa_aw_arbiter_if
// Bundles the dispatcher-side AW requests, the slave AW channel and the
// WDATA ordering-FIFO push port that belong to one slave-side AW arbiter.
//   modport slave  : the arbiter's view. It takes requests and drives the
//                    slave AW channel and the FIFO push.
//   modport master : the environment's view (dispatchers, slave, FIFO).
// Optional macro SA_AW_OUTSTANDING_LIMIT_EN adds B_handshake_i. The arbiter
// uses it to count writes that are granted but not yet answered.
// ----------------------------------------------------------------------------
interface sa_aw_arbiter_if #(
    parameter int MST_AMT          = 3,
    parameter int MST_ID_W         = sa_pkg::sa_mst_id_w(MST_AMT),
    parameter int TRANS_ID_W       = 4,
    parameter int ADDR_WIDTH       = 32,
    parameter int TRANS_DATA_LEN_W = 3
);
    // Dispatcher side. Master i occupies slice i of each vector.
    logic [TRANS_ID_W*MST_AMT-1:0]       dsp_AWID_i;
    logic [ADDR_WIDTH*MST_AMT-1:0]       dsp_AWADDR_i;
    logic [TRANS_DATA_LEN_W*MST_AMT-1:0] dsp_AWLEN_i;
    logic [MST_AMT-1:0]                  dsp_AWVALID_i;
    logic [MST_AMT-1:0]                  dsp_slv_sel_i;
    logic [MST_AMT-1:0]                  dsp_AWREADY_o;

    // Slave AW channel
    logic [MST_ID_W+TRANS_ID_W-1:0]      s_AWID_o;
    logic [ADDR_WIDTH-1:0]               s_AWADDR_o;
    logic [TRANS_DATA_LEN_W-1:0]         s_AWLEN_o;
    logic                                s_AWVALID_o;
    logic                                s_AWREADY_i;

    // WDATA ordering FIFO
    logic                                WD_stall_i;
    logic [MST_ID_W-1:0]                 WD_mst_id_o;
    logic [TRANS_DATA_LEN_W-1:0]         WD_AxLEN_o;
    logic                                WD_fifo_order_wr_en_o;

`ifdef SA_AW_OUTSTANDING_LIMIT_EN
    logic                                B_handshake_i;

    modport slave (
        input  dsp_AWID_i, dsp_AWADDR_i, dsp_AWLEN_i, dsp_AWVALID_i, dsp_slv_sel_i,
        output dsp_AWREADY_o,
        output s_AWID_o, s_AWADDR_o, s_AWLEN_o, s_AWVALID_o,
        input  s_AWREADY_i,
        input  WD_stall_i,
        output WD_mst_id_o, WD_AxLEN_o, WD_fifo_order_wr_en_o,
        input  B_handshake_i
    );

    modport master (
        output dsp_AWID_i, dsp_AWADDR_i, dsp_AWLEN_i, dsp_AWVALID_i, dsp_slv_sel_i,
        input  dsp_AWREADY_o,
        input  s_AWID_o, s_AWADDR_o, s_AWLEN_o, s_AWVALID_o,
        output s_AWREADY_i,
        output WD_stall_i,
        input  WD_mst_id_o, WD_AxLEN_o, WD_fifo_order_wr_en_o,
        output B_handshake_i
    );
`else
    modport slave (
        input  dsp_AWID_i, dsp_AWADDR_i, dsp_AWLEN_i, dsp_AWVALID_i, dsp_slv_sel_i,
        output dsp_AWREADY_o,
        output s_AWID_o, s_AWADDR_o, s_AWLEN_o, s_AWVALID_o,
        input  s_AWREADY_i,
        input  WD_stall_i,
        output WD_mst_id_o, WD_AxLEN_o, WD_fifo_order_wr_en_o
    );

    modport master (
        output dsp_AWID_i, dsp_AWADDR_i, dsp_AWLEN_i, dsp_AWVALID_i, dsp_slv_sel_i,
        input  dsp_AWREADY_o,
        input  s_AWID_o, s_AWADDR_o, s_AWLEN_o, s_AWVALID_o,
        output s_AWREADY_i,
        output WD_stall_i,
        input  WD_mst_id_o, WD_AxLEN_o, WD_fifo_order_wr_en_o
    );
`endif

endinterface

// File: rtl/sa_rr_arbiter.sv
// ----------------------------------------------------------------------------
// sa_rr_arbiter
// Combinational round-robin pick. It returns the first set request bit at or
// above ptr, and wraps to the low bits when nothing at or above ptr is set.
// The pointer register lives in the parent.
//   req   in  N      request vector
//   ptr   in  IDX_W  highest-priority index
//   gnt   out N      one-hot grant (all zero if no request)
//   idx   out IDX_W  encoded index of gnt
//   found out 1      at least one request present
// ----------------------------------------------------------------------------
module sa_rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = 2
)(
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        // First pass: indices from ptr upward
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
        // Wrap-around pass: only reached when nothing at/above ptr requested
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                found  = 1'b1;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/sa_aw_arbiter.sv
// ----------------------------------------------------------------------------
// sa_aw_arbiter
// Slave-side write-address scheduler for one interconnect slave port.
// Each cycle it picks one dispatcher AW request round-robin and acknowledges
// it combinationally on dsp_AWREADY_o. In the same cycle it pushes
// {master id, AxLEN} into the WDATA ordering FIFO. The chosen request is
// registered onto the slave AW channel, and s_AWID_o is extended with the
// master index. Granting stops while the ordering FIFO reports full, or
// while the slave AW slot is occupied and not being accepted.
// Ports:
//   ACLK_i    clock
//   ARESET_i  asynchronous active-high reset
//   bus       sa_aw_arbiter_if.slave: dispatcher AW requests and AWREADY,
//             slave AW channel, WD_stall_i and the ordering-FIFO push
// Optional macro SA_AW_OUTSTANDING_LIMIT_EN: counts writes that are granted
// but not yet answered (the count goes down on bus.B_handshake_i) and stops
// granting at OUTSTANDING_AMT.
// ----------------------------------------------------------------------------
module sa_aw_arbiter
    import sa_pkg::*;
#(
    parameter int MST_AMT          = 3,
    parameter int MST_ID_W         = sa_mst_id_w(MST_AMT),
    parameter int TRANS_ID_W       = 4,
    parameter int ADDR_WIDTH       = 32,
    parameter int TRANS_DATA_LEN_W = 3,
    parameter int OUTSTANDING_AMT  = 8
)(
    input  logic           ACLK_i,
    input  logic           ARESET_i,
    sa_aw_arbiter_if.slave bus
);

    if (MST_AMT < 1) begin : g_bad_mst_amt
        $error("sa_aw_arbiter: MST_AMT must be at least 1");
    end
    if (MST_ID_W < sa_mst_id_w(MST_AMT)) begin : g_bad_mst_id_w
        $error("sa_aw_arbiter: MST_ID_W too narrow for MST_AMT");
    end
    if (OUTSTANDING_AMT < 1) begin : g_bad_outstanding
        $error("sa_aw_arbiter: OUTSTANDING_AMT must be at least 1");
    end

    sa_aw_state_t                   state, state_nxt;
    logic [MST_AMT-1:0]             req;
    logic [MST_AMT-1:0]             gnt;
    logic [MST_ID_W-1:0]            gnt_idx;
    logic                           gnt_found;
    logic [MST_ID_W-1:0]            prio_ptr, prio_ptr_nxt;
    logic                           slot_free;
    logic                           handshake;
    logic                           limit_ok;
    logic                           grant_ok;

    logic [TRANS_ID_W-1:0]          sel_id;
    logic [ADDR_WIDTH-1:0]          sel_addr;
    logic [TRANS_DATA_LEN_W-1:0]    sel_len;

    logic [MST_ID_W+TRANS_ID_W-1:0] aw_id_p1;
    logic [ADDR_WIDTH-1:0]          aw_addr_p1;
    logic [TRANS_DATA_LEN_W-1:0]    aw_len_p1;

    // ------------------------------------------------------------------
    // Request qualification and grant decision
    // ------------------------------------------------------------------
    assign req       = bus.dsp_AWVALID_i & bus.dsp_slv_sel_i;
    assign slot_free = (state == SA_AW_IDLE) | bus.s_AWREADY_i;
    assign handshake = (state == SA_AW_ISSUE) & bus.s_AWREADY_i;

    // Holding reset in the grant term keeps every combinational output at 0
    // during reset, so no FIFO push leaks out while the block is reset.
    assign grant_ok  = slot_free & ~bus.WD_stall_i & gnt_found & limit_ok & ~ARESET_i;

    sa_rr_arbiter #(
        .N     (MST_AMT),
        .IDX_W (MST_ID_W)
    ) u_rr (
        .req   (req),
        .ptr   (prio_ptr),
        .gnt   (gnt),
        .idx   (gnt_idx),
        .found (gnt_found)
    );

    // One-hot mux of the granted master's request fields
    always_comb begin
        sel_id   = '0;
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < MST_AMT; i++) begin
            if (gnt[i]) begin
                sel_id   = bus.dsp_AWID_i[i*TRANS_ID_W +: TRANS_ID_W];
                sel_addr = bus.dsp_AWADDR_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len  = bus.dsp_AWLEN_i[i*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
            end
        end
    end

    // With a single master, gnt_idx is always 0 and equals MST_AMT-1, so the
    // pointer stays at 0 without a special case.
    assign prio_ptr_nxt = (gnt_idx == MST_ID_W'(MST_AMT - 1)) ? '0
                                                              : gnt_idx + MST_ID_W'(1);

    assign bus.dsp_AWREADY_o         = grant_ok ? gnt : '0;
    assign bus.WD_fifo_order_wr_en_o = grant_ok;
    assign bus.WD_mst_id_o           = grant_ok ? gnt_idx : '0;
    assign bus.WD_AxLEN_o            = grant_ok ? sel_len : '0;

`ifdef SA_AW_OUTSTANDING_LIMIT_EN
    localparam int CNT_W = $clog2(OUTSTANDING_AMT + 1);

    logic [CNT_W-1:0] out_cnt;

    assign limit_ok = (out_cnt < CNT_W'(OUTSTANDING_AMT));

    // A grant and a B response in the same cycle cancel out. A B response
    // that arrives with the count at 0 is dropped, so the count never
    // underflows.
    always_ff @(posedge ACLK_i or posedge ARESET_i) begin
        if (ARESET_i) begin
            out_cnt <= '0;
        end else if (grant_ok && !bus.B_handshake_i) begin
            out_cnt <= out_cnt + CNT_W'(1);
        end else if (!grant_ok && bus.B_handshake_i && (out_cnt != '0)) begin
            out_cnt <= out_cnt - CNT_W'(1);
        end
    end
`else
    assign limit_ok = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Slave AW slot FSM: the state is s_AWVALID_o
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            SA_AW_IDLE: begin
                if (grant_ok) state_nxt = SA_AW_ISSUE;
            end
            SA_AW_ISSUE: begin
                if (handshake && !grant_ok) state_nxt = SA_AW_IDLE;
            end
            default: state_nxt = SA_AW_IDLE;
        endcase
    end

    always_ff @(posedge ACLK_i or posedge ARESET_i) begin
        if (ARESET_i) begin
            state    <= SA_AW_IDLE;
            prio_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (grant_ok) prio_ptr <= prio_ptr_nxt;
        end
    end

    // ------------------------------------------------------------------
    // p1: registered slave AW payload, loaded only on a grant
    // ------------------------------------------------------------------
    // A grant implies the slot is free (empty or handing off this cycle),
    // so a back-to-back reload never overwrites an unaccepted AW.
    always_ff @(posedge ACLK_i or posedge ARESET_i) begin
        if (ARESET_i) begin
            aw_id_p1   <= '0;
            aw_addr_p1 <= '0;
            aw_len_p1  <= '0;
        end else if (grant_ok) begin
            aw_id_p1   <= {gnt_idx, sel_id};
            aw_addr_p1 <= sel_addr;
            aw_len_p1  <= sel_len;
        end
    end

    assign bus.s_AWVALID_o = (state == SA_AW_ISSUE);
    assign bus.s_AWID_o    = aw_id_p1;
    assign bus.s_AWADDR_o  = aw_addr_p1;
    assign bus.s_AWLEN_o   = aw_len_p1;

endmodule

// File: tb/tb_sa_aw_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sa_aw_arbiter
// Directed bench for sa_aw_arbiter (3 masters). Inputs change 1 ns after
// the rising edge. Outputs are sampled 1 ns after that.
// Optional macro SA_AW_OUTSTANDING_LIMIT_EN enables the outstanding-limit
// scenario, with OUTSTANDING_AMT = 2.
// ----------------------------------------------------------------------------
module tb_sa_aw_arbiter;

    localparam int MST_AMT    = 3;
    localparam int MST_ID_W   = 2;
    localparam int TRANS_ID_W = 4;
    localparam int ADDR_W     = 32;
    localparam int LEN_W      = 3;
`ifdef SA_AW_OUTSTANDING_LIMIT_EN
    localparam int OUT_AMT    = 2;
`else
    localparam int OUT_AMT    = 8;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sa_aw_arbiter_if #(
        .MST_AMT          (MST_AMT),
        .MST_ID_W         (MST_ID_W),
        .TRANS_ID_W       (TRANS_ID_W),
        .ADDR_WIDTH       (ADDR_W),
        .TRANS_DATA_LEN_W (LEN_W)
    ) bus ();

    sa_aw_arbiter #(
        .MST_AMT          (MST_AMT),
        .MST_ID_W         (MST_ID_W),
        .TRANS_ID_W       (TRANS_ID_W),
        .ADDR_WIDTH       (ADDR_W),
        .TRANS_DATA_LEN_W (LEN_W),
        .OUTSTANDING_AMT  (OUT_AMT)
    ) dut (
        .ACLK_i   (clk),
        .ARESET_i (rst),
        .bus      (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    // Master i: AWID = i+5, AWADDR = 0x1000*(i+1), AWLEN = i+1
    task automatic load_pattern();
        for (int i = 0; i < MST_AMT; i++) begin
            bus.dsp_AWID_i[i*TRANS_ID_W +: TRANS_ID_W] = TRANS_ID_W'(i + 5);
            bus.dsp_AWADDR_i[i*ADDR_W +: ADDR_W]       = ADDR_W'(32'h1000 * (i + 1));
            bus.dsp_AWLEN_i[i*LEN_W +: LEN_W]          = LEN_W'(i + 1);
        end
    endtask

    task automatic test_reset();
        bus.dsp_AWVALID_i = 3'b111;
        bus.dsp_slv_sel_i = 3'b111;
        bus.s_AWREADY_i   = 1'b1;
        #1;
        checks++;
        if (bus.s_AWVALID_o !== 1'b0) begin errors++; $display("FAIL reset_awvalid got %b exp 0", bus.s_AWVALID_o); end
        checks++;
        if (bus.s_AWID_o !== 6'h00) begin errors++; $display("FAIL reset_awid got %h exp 00", bus.s_AWID_o); end
        checks++;
        if (bus.s_AWADDR_o !== 32'h0) begin errors++; $display("FAIL reset_awaddr got %h exp 0", bus.s_AWADDR_o); end
        checks++;
        if (bus.s_AWLEN_o !== 3'd0) begin errors++; $display("FAIL reset_awlen got %0d exp 0", bus.s_AWLEN_o); end
        checks++;
        if (bus.dsp_AWREADY_o !== 3'b000) begin errors++; $display("FAIL reset_dsp_awready got %b exp 000", bus.dsp_AWREADY_o); end
        checks++;
        if (bus.WD_fifo_order_wr_en_o !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", bus.WD_fifo_order_wr_en_o); end
        bus.dsp_AWVALID_i = 3'b000;
        rst = 1'b0;
    endtask

    task automatic test_single();
        step();
        bus.dsp_AWID_i[TRANS_ID_W +: TRANS_ID_W] = 4'hA;
        bus.dsp_AWADDR_i[ADDR_W +: ADDR_W]       = 32'h100;
        bus.dsp_AWLEN_i[LEN_W +: LEN_W]          = 3'd3;
        bus.dsp_AWVALID_i = 3'b010;
        bus.dsp_slv_sel_i = 3'b111;
        bus.s_AWREADY_i   = 1'b1;
        #1;
        checks++;
        if (bus.dsp_AWREADY_o !== 3'b010) begin errors++; $display("FAIL single_awready got %b exp 010", bus.dsp_AWREADY_o); end
        checks++;
        if (bus.WD_fifo_order_wr_en_o !== 1'b1) begin errors++; $display("FAIL single_wr_en got %b exp 1", bus.WD_fifo_order_wr_en_o); end
        checks++;
        if (bus.WD_mst_id_o !== 2'd1) begin errors++; $display("FAIL single_mst_id got %0d exp 1", bus.WD_mst_id_o); end
        checks++;
        if (bus.WD_AxLEN_o !== 3'd3) begin errors++; $display("FAIL single_axlen got %0d exp 3", bus.WD_AxLEN_o); end
        step();
        bus.dsp_AWVALID_i = 3'b000;
        #1;
        checks++;
        if (bus.s_AWVALID_o !== 1'b1) begin errors++; $display("FAIL single_awvalid got %b exp 1", bus.s_AWVALID_o); end
        checks++;
        if (bus.s_AWID_o !== 6'h1A) begin errors++; $display("FAIL single_awid got %h exp 1a", bus.s_AWID_o); end
        checks++;
        if (bus.s_AWADDR_o !== 32'h100) begin errors++; $display("FAIL single_awaddr got %h exp 100", bus.s_AWADDR_o); end
        checks++;
        if (bus.s_AWLEN_o !== 3'd3) begin errors++; $display("FAIL single_awlen got %0d exp 3", bus.s_AWLEN_o); end
        checks++;
        if (bus.WD_fifo_order_wr_en_o !== 1'b0) begin errors++; $display("FAIL single_no_push got %b exp 0", bus.WD_fifo_order_wr_en_o); end
        step();
        #1;
        checks++;
        if (bus.s_AWVALID_o !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", bus.s_AWVALID_o); end
    endtask

    task automatic test_fairness();
        logic [5:0] exp_id;
        int         prev;
        pulse_reset();
        step();
        load_pattern();
        bus.dsp_AWVALID_i = 3'b111;
        bus.dsp_slv_sel_i = 3'b111;
        bus.s_AWREADY_i   = 1'b1;
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (bus.dsp_AWREADY_o !== 3'(1 << (i % 3))) begin
                errors++; $display("FAIL fair_awready[%0d] got %b exp %b", i, bus.dsp_AWREADY_o, 3'(1 << (i % 3)));
            end
            checks++;
            if (bus.WD_fifo_order_wr_en_o !== 1'b1 || bus.WD_mst_id_o !== 2'(i % 3) || bus.WD_AxLEN_o !== 3'((i % 3) + 1)) begin
                errors++; $display("FAIL fair_push[%0d] got en=%b id=%0d len=%0d exp en=1 id=%0d len=%0d", i,
                                   bus.WD_fifo_order_wr_en_o, bus.WD_mst_id_o, bus.WD_AxLEN_o, i % 3, (i % 3) + 1);
            end
            if (i > 0) begin
                exp_id = {2'(prev), 4'(prev + 5)};
                checks++;
                if (bus.s_AWVALID_o !== 1'b1 || bus.s_AWID_o !== exp_id) begin
                    errors++; $display("FAIL fair_slave[%0d] got v=%b id=%h exp v=1 id=%h", i, bus.s_AWVALID_o, bus.s_AWID_o, exp_id);
                end
            end
            prev = i % 3;
            step();
        end
    endtask

    task automatic test_backpressure();
        bus.s_AWREADY_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus.dsp_AWREADY_o !== 3'b000 || bus.WD_fifo_order_wr_en_o !== 1'b0) begin
                errors++; $display("FAIL bp_no_grant[%0d] got rdy=%b en=%b exp rdy=000 en=0", i, bus.dsp_AWREADY_o, bus.WD_fifo_order_wr_en_o);
            end
            checks++;
            if (bus.s_AWVALID_o !== 1'b1 || bus.s_AWID_o !== 6'h27 || bus.s_AWADDR_o !== 32'h3000) begin
                errors++; $display("FAIL bp_hold[%0d] got v=%b id=%h addr=%h exp v=1 id=27 addr=3000", i,
                                   bus.s_AWVALID_o, bus.s_AWID_o, bus.s_AWADDR_o);
            end
            step();
        end
        bus.s_AWREADY_i = 1'b1;
        #1;
        checks++;
        if (bus.dsp_AWREADY_o !== 3'b001 || bus.WD_mst_id_o !== 2'd0) begin
            errors++; $display("FAIL bp_release got rdy=%b id=%0d exp rdy=001 id=0", bus.dsp_AWREADY_o, bus.WD_mst_id_o);
        end
        step();
        #1;
        checks++;
        if (bus.s_AWVALID_o !== 1'b1 || bus.s_AWID_o !== 6'h05 || bus.s_AWADDR_o !== 32'h1000) begin
            errors++; $display("FAIL bp_reload got v=%b id=%h addr=%h exp v=1 id=05 addr=1000", bus.s_AWVALID_o, bus.s_AWID_o, bus.s_AWADDR_o);
        end
        bus.dsp_AWVALID_i = 3'b000;
    endtask

    task automatic test_stall();
        bus.dsp_AWVALID_i = 3'b111;
        bus.WD_stall_i    = 1'b1;
        #1;
        checks++;
        if (bus.dsp_AWREADY_o !== 3'b000 || bus.WD_fifo_order_wr_en_o !== 1'b0) begin
            errors++; $display("FAIL stall_block got rdy=%b en=%b exp rdy=000 en=0", bus.dsp_AWREADY_o, bus.WD_fifo_order_wr_en_o);
        end
        checks++;
        if (bus.s_AWVALID_o !== 1'b1) begin errors++; $display("FAIL stall_pending got %b exp 1", bus.s_AWVALID_o); end
        step();
        #1;
        checks++;
        if (bus.s_AWVALID_o !== 1'b0 || bus.dsp_AWREADY_o !== 3'b000) begin
            errors++; $display("FAIL stall_complete got v=%b rdy=%b exp v=0 rdy=000", bus.s_AWVALID_o, bus.dsp_AWREADY_o);
        end
        bus.WD_stall_i = 1'b0;
        #1;
        checks++;
        if (bus.dsp_AWREADY_o !== 3'b010 || bus.WD_mst_id_o !== 2'd1) begin
            errors++; $display("FAIL stall_release got rdy=%b id=%0d exp rdy=010 id=1", bus.dsp_AWREADY_o, bus.WD_mst_id_o);
        end
        step();
        #1;
        checks++;
        if (bus.s_AWVALID_o !== 1'b1 || bus.s_AWID_o !== 6'h16) begin
            errors++; $display("FAIL stall_issue got v=%b id=%h exp v=1 id=16", bus.s_AWVALID_o, bus.s_AWID_o);
        end
        bus.dsp_AWVALID_i = 3'b000;
        step();
    endtask

    task automatic test_slave_sel();
        bus.dsp_AWVALID_i = 3'b111;
        bus.dsp_slv_sel_i = 3'b100;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (bus.dsp_AWREADY_o !== 3'b100 || bus.WD_mst_id_o !== 2'd2) begin
                errors++; $display("FAIL sel_only2[%0d] got rdy=%b id=%0d exp rdy=100 id=2", i, bus.dsp_AWREADY_o, bus.WD_mst_id_o);
            end
            step();
        end
        bus.dsp_AWVALID_i = 3'b000;
        bus.dsp_slv_sel_i = 3'b111;
        step();
    endtask

    task automatic test_async_reset();
        bus.dsp_AWVALID_i = 3'b001;
        bus.s_AWREADY_i   = 1'b0;
        #1;
        checks++;
        if (bus.dsp_AWREADY_o !== 3'b001) begin errors++; $display("FAIL areset_pre_grant got %b exp 001", bus.dsp_AWREADY_o); end
        step();
        bus.dsp_AWVALID_i = 3'b111;
        #1;
        checks++;
        if (bus.s_AWVALID_o !== 1'b1) begin errors++; $display("FAIL areset_pre_valid got %b exp 1", bus.s_AWVALID_o); end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.s_AWVALID_o !== 1'b0 || bus.s_AWID_o !== 6'h00 || bus.s_AWADDR_o !== 32'h0) begin
            errors++; $display("FAIL areset_clear got v=%b id=%h addr=%h exp v=0 id=00 addr=0", bus.s_AWVALID_o, bus.s_AWID_o, bus.s_AWADDR_o);
        end
        checks++;
        if (bus.dsp_AWREADY_o !== 3'b000 || bus.WD_fifo_order_wr_en_o !== 1'b0) begin
            errors++; $display("FAIL areset_comb got rdy=%b en=%b exp rdy=000 en=0", bus.dsp_AWREADY_o, bus.WD_fifo_order_wr_en_o);
        end
        rst = 1'b0;
        bus.s_AWREADY_i = 1'b1;
        #1;
        checks++;
        if (bus.dsp_AWREADY_o !== 3'b001 || bus.WD_fifo_order_wr_en_o !== 1'b1) begin
            errors++; $display("FAIL areset_ptr0 got rdy=%b en=%b exp rdy=001 en=1", bus.dsp_AWREADY_o, bus.WD_fifo_order_wr_en_o);
        end
        bus.dsp_AWVALID_i = 3'b000;
        step();
    endtask

`ifdef SA_AW_OUTSTANDING_LIMIT_EN
    task automatic test_outstanding();
        pulse_reset();
        step();
        bus.dsp_AWVALID_i = 3'b001;
        bus.s_AWREADY_i   = 1'b1;
        bus.B_handshake_i = 1'b0;
        #1;
        checks++;
        if (bus.dsp_AWREADY_o !== 3'b001) begin errors++; $display("FAIL ost_first got %b exp 001", bus.dsp_AWREADY_o); end
        step();
        #1;
        checks++;
        if (bus.dsp_AWREADY_o !== 3'b001) begin errors++; $display("FAIL ost_second got %b exp 001", bus.dsp_AWREADY_o); end
        step();
        #1;
        checks++;
        if (bus.dsp_AWREADY_o !== 3'b000) begin errors++; $display("FAIL ost_third_wait got %b exp 000", bus.dsp_AWREADY_o); end
        bus.B_handshake_i = 1'b1;
        #1;
        checks++;
        if (bus.dsp_AWREADY_o !== 3'b000) begin errors++; $display("FAIL ost_b_cycle got %b exp 000", bus.dsp_AWREADY_o); end
        step();
        bus.B_handshake_i = 1'b0;
        #1;
        checks++;
        if (bus.dsp_AWREADY_o !== 3'b001) begin errors++; $display("FAIL ost_third_go got %b exp 001", bus.dsp_AWREADY_o); end
        bus.dsp_AWVALID_i = 3'b000;
        step();
    endtask
`endif

    initial begin
        #20000;
        $display("FAIL watchdog timeout, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        bus.dsp_AWID_i    = '0;
        bus.dsp_AWADDR_i  = '0;
        bus.dsp_AWLEN_i   = '0;
        bus.dsp_AWVALID_i = '0;
        bus.dsp_slv_sel_i = '0;
        bus.s_AWREADY_i   = 1'b0;
        bus.WD_stall_i    = 1'b0;
`ifdef SA_AW_OUTSTANDING_LIMIT_EN
        bus.B_handshake_i = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_stall();
        test_slave_sel();
        test_async_reset();
`ifdef SA_AW_OUTSTANDING_LIMIT_EN
        test_outstanding();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
